sd_audio_stream: RTL and testbench

- SD read client that sits on the requester side of the SD manager's per-client read handshake.
- Streams a clip of consecutive SD sectors into a two-bank ping-pong buffer.
- Plays the buffered bytes out as unsigned 8-bit audio samples at a fixed sample rate.
- Used for longer clips (voice/jingles), alongside the existing bgm and sound-effect clients.

---
 rtl/sd_audio_stream_if.sv | 24 ++
 rtl/sd_audio_stream.sv | 236 +++++++++++++++++++++++
 tb/tb_sd_audio_stream.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_audio_stream_if.sv
// rtl/sd_audio_stream_if.sv - per-client read handshake between an SD client and the SD manager
interface sd_audio_stream_if;
    logic        request_sd_read;
    logic [31:0] sd_addr;
    logic        sd_read_accepted;
    logic        sd_byte_available;
    logic [7:0]  sd_dout;

    modport master (
        output request_sd_read,
        output sd_addr,
        input  sd_read_accepted,
        input  sd_byte_available,
        input  sd_dout
    );

    modport slave (
        input  request_sd_read,
        input  sd_addr,
        output sd_read_accepted,
        output sd_byte_available,
        output sd_dout
    );
endinterface

// File: rtl/sd_audio_stream.sv
// rtl/sd_audio_stream.sv - streams consecutive SD sectors through a ping-pong buffer as 8-bit audio
module sd_audio_stream #(
    parameter int         SAMPLE_DIV   = 8125,
    parameter int         SECTOR_BYTES = 512,
    parameter logic [7:0] SILENCE      = 8'h80
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] start_sector,
    input  logic [15:0] num_sectors,
    sd_audio_stream_if.master sd,
    output logic [7:0]  audio_out,
    output logic        sample_strobe,
    output logic        busy,
    output logic        done,
    output logic        underrun
);
    localparam int BW = $clog2(SECTOR_BYTES);
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(SECTOR_BYTES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQUEST   = 3'd1;
    localparam logic [2:0] S_RECEIVE   = 3'd2;
    localparam logic [2:0] S_WAIT_BANK = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;
    localparam logic [2:0] S_FLUSH     = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [31:0]   cur_sector_q, cur_sector_d;
    logic [15:0]   sectors_left_q, sectors_left_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [BW-1:0] play_idx_q, play_idx_d;
    logic          fill_bank_q, fill_bank_d;
    logic          play_bank_q, play_bank_d;
    logic [1:0]    bank_valid_q, bank_valid_d;
    logic [DW-1:0] div_q, div_d;
    logic          avail_prev_q;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          p1_q, p1_d;
    logic          p1_under_q, p1_under_d;
    logic [7:0]    audio_q, audio_d;
    logic          strobe_q, strobe_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    rd_data_q;

    logic [7:0]    mem [2*SECTOR_BYTES];
    logic          wr_en, byte_stb, stop_acc, tick;
    logic [BW:0]   wr_addr, rd_addr;

    assign wr_addr = {fill_bank_q, byte_cnt_q};
    assign rd_addr = {play_bank_q, play_idx_q};

    always_comb begin
        state_d        = state_q;
        cur_sector_d   = cur_sector_q;
        sectors_left_d = sectors_left_q;
        byte_cnt_d     = byte_cnt_q;
        play_idx_d     = play_idx_q;
        fill_bank_d    = fill_bank_q;
        play_bank_d    = play_bank_q;
        bank_valid_d   = bank_valid_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        audio_d        = audio_q;
        wr_en          = 1'b0;
        byte_stb       = sd.sd_byte_available & ~avail_prev_q;
        stop_acc       = stop & busy_q;
        tick           = busy_q && (div_q == '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_sectors != 16'd0) begin
                        cur_sector_d   = start_sector;
                        sectors_left_d = num_sectors;
                        busy_d         = 1'b1;
                        fill_bank_d    = 1'b0;
                        play_bank_d    = 1'b0;
                        play_idx_d     = '0;
                        bank_valid_d   = 2'b00;
                        state_d        = S_REQUEST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_REQUEST: begin
                // A grant seen together with stop still commits us to the whole sector.
                if (sd.sd_read_accepted) begin
                    byte_cnt_d = '0;
                    state_d    = stop_acc ? S_FLUSH : S_RECEIVE;
                end else if (stop_acc) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RECEIVE: begin
                if (byte_stb) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    wr_en      = ~stop_acc;
                end
                if (byte_stb && byte_cnt_q == LAST_IDX) begin
                    if (stop_acc) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        bank_valid_d[fill_bank_q] = 1'b1;
                        fill_bank_d    = ~fill_bank_q;
                        cur_sector_d   = cur_sector_q + 32'd1;
                        sectors_left_d = sectors_left_q - 16'd1;
                        state_d        = (sectors_left_q == 16'd1) ? S_FINISH : S_WAIT_BANK;
                    end
                end else if (stop_acc) begin
                    state_d = S_FLUSH;
                end
            end
            S_WAIT_BANK: begin
                if (stop_acc) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!bank_valid_q[fill_bank_q]) begin
                    state_d = S_REQUEST;
                end
            end
            S_FINISH: begin
                // Wait for the last sample to leave the read pipeline before signalling done.
                if (stop_acc || (bank_valid_q == 2'b00 && !p1_q)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (byte_stb) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        div_d = '0;
        if (busy_q) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

        p1_d       = tick;
        p1_under_d = tick & ~bank_valid_q[play_bank_q];
        if (tick && bank_valid_q[play_bank_q]) begin
            if (play_idx_q == LAST_IDX) begin
                bank_valid_d[play_bank_q] = 1'b0;
                play_bank_d = ~play_bank_q;
                play_idx_d  = '0;
            end else begin
                play_idx_d = play_idx_q + 1'b1;
            end
        end

        strobe_d   = p1_q;
        underrun_d = p1_q & p1_under_q;
        if (p1_q) audio_d = p1_under_q ? SILENCE : rd_data_q;
        if (done_d) audio_d = SILENCE;

        if (stop_acc) begin
            bank_valid_d = 2'b00;
            audio_d      = SILENCE;
            strobe_d     = 1'b0;
            underrun_d   = 1'b0;
            p1_d         = 1'b0;
            p1_under_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q        <= S_IDLE;
            cur_sector_q   <= '0;
            sectors_left_q <= '0;
            byte_cnt_q     <= '0;
            play_idx_q     <= '0;
            fill_bank_q    <= 1'b0;
            play_bank_q    <= 1'b0;
            bank_valid_q   <= 2'b00;
            div_q          <= '0;
            avail_prev_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            p1_q           <= 1'b0;
            p1_under_q     <= 1'b0;
            audio_q        <= SILENCE;
            strobe_q       <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_sector_q   <= cur_sector_d;
            sectors_left_q <= sectors_left_d;
            byte_cnt_q     <= byte_cnt_d;
            play_idx_q     <= play_idx_d;
            fill_bank_q    <= fill_bank_d;
            play_bank_q    <= play_bank_d;
            bank_valid_q   <= bank_valid_d;
            div_q          <= div_d;
            avail_prev_q   <= sd.sd_byte_available;
            busy_q         <= busy_d;
            done_q         <= done_d;
            p1_q           <= p1_d;
            p1_under_q     <= p1_under_d;
            audio_q        <= audio_d;
            strobe_q       <= strobe_d;
            underrun_q     <= underrun_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= sd.sd_dout;
        rd_data_q <= mem[rd_addr];
    end

    assign sd.request_sd_read = (state_q == S_REQUEST) && !stop_acc;
    assign sd.sd_addr         = cur_sector_q;
    assign audio_out          = audio_q;
    assign sample_strobe      = strobe_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign underrun           = underrun_q;
endmodule

// File: tb/tb_sd_audio_stream.sv
// tb/tb_sd_audio_stream.sv - scoreboard bench with an SD manager model for sd_audio_stream
module tb_sd_audio_stream;
    localparam int         SB  = 8;
    localparam int         DIV = 4;
    localparam logic [7:0] SIL = 8'h80;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] start_sector = '0;
    logic [15:0] num_sectors = '0;
    logic [7:0]  audio_out;
    logic        sample_strobe, busy, done, underrun;

    sd_audio_stream_if sdif ();

    sd_audio_stream #(.SAMPLE_DIV(DIV), .SECTOR_BYTES(SB), .SILENCE(SIL)) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .start        (start),
        .stop         (stop),
        .start_sector (start_sector),
        .num_sectors  (num_sectors),
        .sd           (sdif),
        .audio_out    (audio_out),
        .sample_strobe(sample_strobe),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun)
    );

    always #5 clk_in = ~clk_in;

    int          checks = 0, errors = 0;
    int          cyc = 0, last_strobe = -1;
    int          under_mid = 0, done_cnt = 0, bytes_sent = 0;
    bit          seen_data = 0, stable_chk = 0;
    int          mul = 1, off = 0, hold_c = 1, gap_c = 1, gdelay = 0;
    logic [31:0] base_sec = '0;
    logic [7:0]  exp_q[$];
    logic [31:0] addr_q[$];

    always @(posedge clk_in) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Content the SD card holds: byte i of sector sec, relative to the clip's first sector.
    function automatic logic [7:0] sd_byte(input logic [31:0] sec, input int i);
        logic [31:0] k;
        k = (sec - base_sec) * SB + i;
        return 8'(k * mul + off);
    endfunction

    always @(negedge clk_in) begin
        if (!reset_in) begin
            if (sample_strobe) begin
                if (last_strobe >= 0) chk("strobe_period", cyc - last_strobe, DIV);
                last_strobe = cyc;
                if (underrun) begin
                    if (seen_data) under_mid++;
                    chk("underrun_silence", audio_out, SIL);
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got 0x%0h with empty scoreboard", audio_out);
                end else begin
                    seen_data = 1;
                    chk("sample", audio_out, exp_q.pop_front());
                end
            end else if (underrun) begin
                chk("underrun_needs_strobe", sample_strobe, 1);
            end
            if (done) begin
                done_cnt++;
                last_strobe = -1;
                chk("done_after_last_sample", exp_q.size(), 0);
            end
        end
    end

    initial begin : manager
        logic [31:0] req_a;
        bit          granted;
        sdif.sd_read_accepted  = 1'b0;
        sdif.sd_byte_available = 1'b0;
        sdif.sd_dout           = '0;
        forever begin
            @(posedge clk_in); #1;
            if (!reset_in && sdif.request_sd_read) begin
                req_a   = sdif.sd_addr;
                granted = 1;
                for (int k = 0; k < gdelay; k++) begin
                    @(posedge clk_in); #1;
                    if (stable_chk) begin
                        chk("req_held", sdif.request_sd_read, 1);
                        chk("addr_held", sdif.sd_addr, req_a);
                    end
                    if (!sdif.request_sd_read) begin
                        granted = 0;
                        break;
                    end
                end
                if (granted) begin
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_request: sd_addr 0x%0h", req_a);
                    end else begin
                        chk("sd_addr", req_a, addr_q.pop_front());
                    end
                    sdif.sd_read_accepted = 1'b1;
                    @(posedge clk_in); #1;
                    sdif.sd_read_accepted = 1'b0;
                    chk("req_drop_after_grant", sdif.request_sd_read, 0);
                    bytes_sent = 0;
                    for (int i = 0; i < SB; i++) begin
                        sdif.sd_dout           = sd_byte(req_a, i);
                        sdif.sd_byte_available = 1'b1;
                        bytes_sent++;
                        repeat (hold_c) @(posedge clk_in);
                        #1;
                        sdif.sd_byte_available = 1'b0;
                        repeat (gap_c) @(posedge clk_in);
                        #1;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] sec, input logic [15:0] n);
        start_sector = sec;
        num_sectors  = n;
        start        = 1'b1;
        step(1);
        start        = 1'b0;
    endtask

    task automatic start_clip(input logic [31:0] sec, input int n);
        base_sec    = sec;
        seen_data   = 0;
        last_strobe = -1;
        for (int s = 0; s < n; s++) addr_q.push_back(sec + 32'(s));
        for (int k = 0; k < n * SB; k++) exp_q.push_back(8'(k * mul + off));
        pulse_start(sec, 16'(n));
    endtask

    task automatic wait_done(input int max, input string name);
        int k;
        k = 0;
        while (!done && k < max) begin
            step(1);
            k++;
        end
        chk({name, "_done_seen"}, done, 1);
        chk({name, "_busy_low_at_done"}, busy, 0);
    endtask

    initial begin : main
        int          d0;
        int          n;
        int          k;
        logic [31:0] sec;

        step(3);
        chk("rst_request", sdif.request_sd_read, 0);
        chk("rst_sd_addr", sdif.sd_addr, 0);
        chk("rst_audio", audio_out, SIL);
        chk("rst_strobe", sample_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        reset_in = 1'b0;
        step(2);

        // Three-sector clip carrying bytes 0x00..0x17.
        d0 = done_cnt;
        start_clip(32'h100, 3);
        chk("busy_after_start", busy, 1);
        wait_done(3000, "basic");
        step(5);
        chk("basic_done_once", done_cnt - d0, 1);

        // Long grant latency, with a start while busy that must not move sd_addr.
        mul = 3; off = 7; gdelay = 50; stable_chk = 1;
        start_clip(32'h2345_6780, 1);
        step(10);
        pulse_start(32'hDEAD_BEEF, 16'd5);
        wait_done(3000, "grant");
        stable_chk = 0; gdelay = 2;
        step(5);

        // Byte strobe held high for several cycles per byte.
        mul = 5; off = 1; hold_c = 5; gap_c = 2;
        start_clip(32'h0000_0040, 2);
        wait_done(3000, "level");
        step(5);

        // Slow source forces underruns between banks.
        mul = 1; off = 8'h33; hold_c = 5; gap_c = 35;
        start_clip(32'h0000_0800, 2);
        wait_done(5000, "slow");
        chk("slow_underrun_mid_clip", under_mid > 0, 1);
        step(5);

        // Abort after three bytes of the first sector.
        mul = 7; off = 2; hold_c = 1; gap_c = 3; gdelay = 0;
        start_clip(32'h0000_1000, 2);
        k = 0;
        while (bytes_sent != 3 && k < 500) begin
            step(1);
            k++;
        end
        chk("abort_third_byte_seen", bytes_sent, 3);
        step(1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        exp_q.delete();
        addr_q.delete();
        last_strobe = -1;
        chk("abort_audio_silence", audio_out, SIL);
        wait_done(1000, "flush");
        chk("flush_absorbed_sector", bytes_sent, SB);
        step(30);
        chk("flush_no_request", sdif.request_sd_read, 0);
        chk("flush_busy_low", busy, 0);

        // Next clip after the abort plays from its first byte.
        mul = 9; off = 4; gap_c = 1;
        start_clip(32'h0000_2000, 1);
        wait_done(3000, "after_abort");
        step(5);

        // Zero-length clip.
        d0 = done_cnt;
        pulse_start(32'h0000_3000, 16'd0);
        chk("zero_done_next_cycle", done, 1);
        chk("zero_busy_low", busy, 0);
        step(20);
        chk("zero_done_count", done_cnt - d0, 1);
        chk("zero_no_request", sdif.request_sd_read, 0);

        for (int r = 0; r < 4; r++) begin
            mul    = int'($urandom_range(255, 0)) | 1;
            off    = int'($urandom_range(255, 0));
            hold_c = int'($urandom_range(3, 1));
            gap_c  = int'($urandom_range(8, 1));
            gdelay = int'($urandom_range(6, 0));
            n      = int'($urandom_range(4, 1));
            sec    = (r == 0) ? 32'hFFFF_FFFE : $urandom;
            start_clip(sec, n);
            wait_done(6000, "random");
            step(5);
        end

        step(10);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("requests_drained", addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
